// File: rtl/flash_key_pkg.sv
// Shared definitions for the key-driven flash erase/program/verify sequencer.
package flash_key_pkg;

    localparam logic [23:0] FLASH_ADDR_DEF  = 24'h000000;
    localparam logic [7:0]  PAGE_LEN_DEF    = 8'd16;
    localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd50_000_000;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_ERASE = 2'd1,
        OP_PROG  = 2'd2
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_ERASE_WAIT,
        ST_PROG,
        ST_PROG_WAIT,
        ST_READ,
        ST_READ_WAIT
    } state_e;

    function automatic logic is_wait(input state_e s);
        return (s == ST_ERASE_WAIT) || (s == ST_PROG_WAIT) || (s == ST_READ_WAIT);
    endfunction

endpackage

// File: rtl/flash_pattern_chk.sv
// Seeded byte pattern generator for page programming and read-back comparator.
module flash_pattern_chk
    import flash_key_pkg::*;
#(
    parameter logic [7:0] PAGE_LEN = PAGE_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_inc,
    input  logic       wr_clr,
    input  logic       wr_adv,
    input  logic       rd_clr,
    input  logic       rd_en,
    input  logic [7:0] rd_data,
    output logic [7:0] wr_data,
    output logic [7:0] rd_idx,
    output logic       err
);

    logic [7:0] seed_q, seed_d;
    logic [7:0] wr_idx_q, wr_idx_d;
    logic [7:0] rd_idx_q, rd_idx_d;
    logic       err_q, err_d;

    always_comb begin
        seed_d   = seed_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        err_d    = err_q;
        if (seed_inc)
            seed_d = seed_q + 8'd1;
        if (wr_clr)
            wr_idx_d = '0;
        else if (wr_adv && (wr_idx_q != PAGE_LEN - 8'd1))
            wr_idx_d = wr_idx_q + 8'd1;
        if (rd_clr) begin
            rd_idx_d = '0;
            err_d    = 1'b0;
        end else if (rd_en) begin
            // Bytes past the page end are errors; the index saturates at PAGE_LEN.
            if (rd_idx_q == PAGE_LEN) begin
                err_d = 1'b1;
            end else begin
                if (rd_data != seed_q + rd_idx_q)
                    err_d = 1'b1;
                rd_idx_d = rd_idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q   <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            err_q    <= 1'b0;
        end else begin
            seed_q   <= seed_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            err_q    <= err_d;
        end
    end

    assign wr_data = seed_q + wr_idx_q;
    assign rd_idx  = rd_idx_q;
    assign err     = err_q;

endmodule

// File: rtl/flash_key_ctrl.sv
// Key-press sequencer: long press erases, programs and verifies a page; short press verifies only.
module flash_key_ctrl
    import flash_key_pkg::*;
#(
    parameter logic [23:0] FLASH_ADDR  = FLASH_ADDR_DEF,
    parameter logic [7:0]  PAGE_LEN    = PAGE_LEN_DEF,
    parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_short,
    input  logic        key_long,
    output logic        cmd_valid,
    output logic [1:0]  cmd_op,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_len,
    input  logic        cmd_ready,
    input  logic        cmd_done,
    output logic [7:0]  wr_data,
    input  logic        wr_req,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic        busy,
    output logic        pass,
    output logic        fail
);

    state_e      state_q, state_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic [31:0] tmo_q, tmo_d;
    logic        seed_inc, wr_clr, rd_clr, wr_adv, rd_en;
    logic [7:0]  rd_idx;
    logic        err;

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tmo_d    = '0;
        seed_inc = 1'b0;
        wr_clr   = 1'b0;
        rd_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_long) begin
                    seed_inc = 1'b1;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    state_d  = ST_ERASE;
                end else if (key_short) begin
                    rd_clr  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    state_d = ST_READ;
                end
            end
            ST_ERASE:      if (cmd_ready) state_d = ST_ERASE_WAIT;
            ST_PROG:       if (cmd_ready) state_d = ST_PROG_WAIT;
            ST_READ:       if (cmd_ready) state_d = ST_READ_WAIT;
            ST_ERASE_WAIT: if (cmd_done) begin
                wr_clr  = 1'b1;
                state_d = ST_PROG;
            end
            ST_PROG_WAIT:  if (cmd_done) begin
                rd_clr  = 1'b1;
                state_d = ST_READ;
            end
            ST_READ_WAIT:  if (cmd_done) begin
                pass_d  = !err && (rd_idx == PAGE_LEN);
                fail_d  = !(!err && (rd_idx == PAGE_LEN));
                state_d = ST_IDLE;
            end
            default:       state_d = ST_IDLE;
        endcase
        // Counter stays zero outside wait states, so it starts at zero on every entry.
        if (is_wait(state_q) && !cmd_done) begin
            if (tmo_q == TIMEOUT_CYC - 32'd1) begin
                fail_d  = 1'b1;
                pass_d  = 1'b0;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd_op    = OP_READ;
        cmd_len   = '0;
        case (state_q)
            ST_ERASE: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_ERASE;
            end
            ST_PROG: begin
                cmd_valid = 1'b1;
                cmd_op    = OP_PROG;
                cmd_len   = PAGE_LEN;
            end
            ST_READ: begin
                cmd_valid = 1'b1;
                cmd_len   = PAGE_LEN;
            end
            default: ;
        endcase
    end

    assign wr_adv   = wr_req && ((state_q == ST_PROG) || (state_q == ST_PROG_WAIT));
    assign rd_en    = rd_valid && ((state_q == ST_READ) || (state_q == ST_READ_WAIT));
    assign cmd_addr = FLASH_ADDR;
    assign busy     = (state_q != ST_IDLE);
    assign pass     = pass_q;
    assign fail     = fail_q;

    flash_pattern_chk #(
        .PAGE_LEN(PAGE_LEN)
    ) u_pat (
        .clk     (clk),
        .rst     (rst),
        .seed_inc(seed_inc),
        .wr_clr  (wr_clr),
        .wr_adv  (wr_adv),
        .rd_clr  (rd_clr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .err     (err)
    );

endmodule
